// File: rtl/l2_access_controller.sv
// Two-port L2 access sequencer: round-robin grant, L2 access,
// block refill from memory on miss, then replay of the access.
module l2_access_controller #(
  parameter int BLOCK_WORDS = 4,
  parameter int OFFSET_SIZE = 4,
  parameter int MISS_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [63:0]           req_addr,
  input  logic [63:0]           req_wdata,
  output logic [1:0]            req_done,
  output logic [31:0]           resp_rdata,
  output logic                  l2_read_en,
  output logic                  l2_write_en,
  output logic [31:0]           l2_address,
  output logic [31:0]           l2_write_data,
  input  logic [31:0]           l2_read_data,
  input  logic                  l2_hit,
  input  logic                  l2_miss,
  output logic                  fill_en,
  output logic [31:0]           fill_address,
  output logic [31:0]           fill_data,
  output logic                  mem_req,
  output logic [31:0]           mem_address,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic [MISS_CNT_W-1:0] miss_count
);

  localparam int BW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BLOCK_WORDS - 1);
  localparam logic [31:0] BASE_MASK =
    ~((32'd1 << OFFSET_SIZE) - 32'd1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, MEM_REQ, MEM_FILL, REPLAY, RESP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            rr;
  logic            grant;
  logic            grant_nx;
  logic            load;
  logic            lat_write;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic [31:0]     base;
  logic [BW-1:0]   beat;

  assign base          = lat_addr & BASE_MASK;
  assign busy          = (state != IDLE);
  assign l2_read_en    = (state == ISSUE) && !lat_write;
  assign l2_write_en   = (state == ISSUE) && lat_write;
  assign l2_address    = lat_addr;
  assign l2_write_data = lat_wdata;
  assign mem_req       = (state == MEM_REQ);
  assign mem_address   = mem_req ? base : 32'd0;
  assign req_done      = (state != RESP) ? 2'b00 :
                         (grant ? 2'b10 : 2'b01);

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          load     = 1'b1;
          state_nx = ISSUE;
          // rr names the requester that wins a tie
          unique case (1'b1)
            req_valid[0] & req_valid[1]:  grant_nx = rr;
            req_valid[1] & ~req_valid[0]: grant_nx = 1'b1;
            default:                      grant_nx = 1'b0;
          endcase
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (l2_hit)       state_nx = RESP;
        else if (l2_miss) state_nx = MEM_REQ;
        else              state_nx = ISSUE;
      end
      MEM_REQ: if (mem_ack) state_nx = MEM_FILL;
      MEM_FILL: begin
        if (mem_rvalid && beat == LAST) state_nx = REPLAY;
      end
      REPLAY: state_nx = ISSUE;
      RESP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      rr           <= 1'b0;
      grant        <= 1'b0;
      lat_write    <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      beat         <= '0;
      resp_rdata   <= '0;
      miss_count   <= '0;
      fill_en      <= 1'b0;
      fill_address <= '0;
      fill_data    <= '0;
    end else begin
      state   <= state_nx;
      fill_en <= 1'b0;
      if (load) begin
        grant     <= grant_nx;
        lat_write <= req_write[grant_nx];
        lat_addr  <= grant_nx ? req_addr[63:32] : req_addr[31:0];
        lat_wdata <= grant_nx ? req_wdata[63:32] : req_wdata[31:0];
      end
      unique case (state)
        WAIT: begin
          if (l2_hit) begin
            if (!lat_write) resp_rdata <= l2_read_data;
          end else if (l2_miss && !(&miss_count)) begin
            miss_count <= miss_count + MISS_CNT_W'(1);
          end
        end
        MEM_REQ: beat <= '0;
        MEM_FILL: begin
          // word captured now is written into L2 next cycle
          if (mem_rvalid) begin
            fill_en      <= 1'b1;
            fill_address <= base | (32'(beat) << 2);
            fill_data    <= mem_rdata;
            beat         <= beat + BW'(1);
          end
        end
        RESP: rr <= ~grant;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_access_controller.sv
// Directed bench for l2_access_controller with L2/memory responders
// and queue-based scoreboards for L2 accesses, fills and responses.
module tb_l2_access_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [63:0]   req_addr;
  logic [63:0]   req_wdata;
  logic [1:0]    req_done;
  logic [31:0]   resp_rdata;
  logic          l2_read_en;
  logic          l2_write_en;
  logic [31:0]   l2_address;
  logic [31:0]   l2_write_data;
  logic [31:0]   l2_read_data;
  logic          l2_hit;
  logic          l2_miss;
  logic          fill_en;
  logic [31:0]   fill_address;
  logic [31:0]   fill_data;
  logic          mem_req;
  logic [31:0]   mem_address;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic [CW-1:0] miss_count;

  always #5 clk = ~clk;

  l2_access_controller #(
    .BLOCK_WORDS(4),
    .OFFSET_SIZE(4),
    .MISS_CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .resp_rdata(resp_rdata),
    .l2_read_en(l2_read_en), .l2_write_en(l2_write_en),
    .l2_address(l2_address), .l2_write_data(l2_write_data),
    .l2_read_data(l2_read_data),
    .l2_hit(l2_hit), .l2_miss(l2_miss),
    .fill_en(fill_en), .fill_address(fill_address),
    .fill_data(fill_data),
    .mem_req(mem_req), .mem_address(mem_address),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .busy(busy), .miss_count(miss_count)
  );

  typedef struct {
    logic [1:0]  done;
    logic [31:0] rdata;
    int          lat;
  } resp_t;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;
  typedef struct {
    logic        miss;
    logic [31:0] rdata;
  } l2o_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } fill_t;

  resp_t       resp_q[$];
  acc_t        acc_q[$];
  l2o_t        l2_q[$];
  fill_t       fill_q[$];
  logic        rv_q[$];
  logic [31:0] beat_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start[2];
  int done_cnt = 0;
  int fill_pulses = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;
  int req_cycles = 0;
  int ack_delay = 0;
  int ack_cnt = 0;
  int fill_idx = 0;
  logic keep = 1'b0;
  logic filling = 1'b0;
  logic force_rv = 1'b0;
  logic prev_strobe = 1'b0;
  logic prev_ack = 1'b0;
  logic [31:0] cur_base = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_resp(input logic [1:0] d, input logic [31:0] r,
                           input int lat);
    resp_t e;
    e.done = d; e.rdata = r; e.lat = lat;
    resp_q.push_back(e);
  endtask

  task automatic push_acc(input logic wr, input logic [31:0] a,
                          input logic [31:0] d);
    acc_t e;
    e.wr = wr; e.addr = a; e.wdata = d;
    acc_q.push_back(e);
  endtask

  task automatic push_l2(input logic m, input logic [31:0] r);
    l2o_t e;
    e.miss = m; e.rdata = r;
    l2_q.push_back(e);
  endtask

  task automatic req(input int i, input logic wr,
                     input logic [31:0] a, input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    if (i == 1) begin
      req_addr[63:32] = a; req_wdata[63:32] = d;
    end else begin
      req_addr[31:0] = a; req_wdata[31:0] = d;
    end
    start[i] = cyc;
    cur_base = a & ~32'hF;
  endtask

  // one clock: observe outputs #1 after the edge, drive next inputs
  task automatic step();
    l2o_t o; resp_t r; acc_t a; fill_t f;
    logic rv_prev, ack_now, b;
    logic [31:0] d;
    int idx;
    @(posedge clk); #1;
    cyc++;
    rv_prev = mem_rvalid;
    l2_hit = 1'b0;
    l2_miss = 1'b0;
    if (prev_strobe) begin
      if (l2_q.size() > 0) o = l2_q.pop_front();
      else begin o.miss = 1'b0; o.rdata = 32'h5A5A_0000; end
      l2_hit = ~o.miss;
      l2_miss = o.miss;
      l2_read_data = o.rdata;
    end
    prev_strobe = l2_read_en | l2_write_en;
    chk("exclusive", {fill_en & prev_strobe,
                      l2_read_en & l2_write_en,
                      mem_req & fill_en,
                      mem_req & prev_strobe}, 0);
    if (prev_strobe) begin
      strobe_cyc = cyc;
      strobe_cnt++;
      if (acc_q.size() == 0) chk("acc_unexpected", 1, 0);
      else begin
        a = acc_q.pop_front();
        chk("acc_write", l2_write_en, a.wr);
        chk("acc_addr", l2_address, a.addr);
        if (a.wr) chk("acc_wdata", l2_write_data, a.wdata);
      end
    end
    if (fill_en) begin
      fill_pulses++;
      chk("fill_after_gap", rv_prev, 1);
      if (fill_q.size() == 0) chk("fill_unexpected", 1, 0);
      else begin
        f = fill_q.pop_front();
        chk("fill_addr", fill_address, f.addr);
        chk("fill_data", fill_data, f.data);
      end
    end
    if (req_done != 2'b00) begin
      done_cnt++;
      idx = req_done[1] ? 1 : 0;
      if (resp_q.size() == 0) chk("resp_unexpected", req_done, 0);
      else begin
        r = resp_q.pop_front();
        chk("resp_done", req_done, r.done);
        chk("resp_rdata", resp_rdata, r.rdata);
        if (r.lat >= 0) chk("resp_latency", cyc - start[idx], r.lat);
      end
      if (!keep) req_valid[idx] = 1'b0;
    end
    if (prev_ack) begin
      chk("mem_req_drop", mem_req, 0);
      filling = 1'b1;
      fill_idx = 0;
    end
    ack_now = 1'b0;
    if (mem_req) begin
      req_cycles++;
      chk("mem_addr", mem_address, cur_base);
      ack_now = (ack_cnt == ack_delay);
      ack_cnt++;
    end else begin
      ack_cnt = 0;
    end
    mem_ack = ack_now;
    prev_ack = ack_now;
    mem_rvalid = 1'b0;
    if (force_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'hEEEE_0000 + 32'(cyc);
    end else if (filling) begin
      b = (rv_q.size() > 0) ? rv_q.pop_front() : 1'b1;
      if (b) begin
        d = (beat_q.size() > 0) ? beat_q.pop_front()
                                : 32'hB000_0000 + 32'(cyc);
        mem_rvalid = 1'b1;
        mem_rdata = d;
        f.addr = cur_base | (32'(fill_idx) << 2);
        f.data = d;
        fill_q.push_back(f);
        fill_idx++;
        if (fill_idx == 4) filling = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int target = done_cnt + n;
    int k = 0;
    while (done_cnt < target && k < budget) begin
      step();
      k++;
    end
    chk("done_timeout", done_cnt >= target, 1);
  endtask

  task automatic wait_fill(input int n, input int budget);
    int target = fill_pulses + n;
    int k = 0;
    while (fill_pulses < target && k < budget) begin
      step();
      k++;
    end
    chk("fill_timeout", fill_pulses >= target, 1);
  endtask

  initial begin
    int s0, f0, d0;
    rst = 1'b0;
    req_valid = '0; req_write = '0;
    req_addr = '0; req_wdata = '0;
    l2_read_data = '0; l2_hit = 1'b0; l2_miss = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", req_done, 0);
    chk("rst_strobes", {l2_read_en, l2_write_en}, 0);
    chk("rst_fill", {fill_en, fill_address, fill_data}, 0);
    chk("rst_mem", {mem_req, mem_address}, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_l2_addr", {l2_address, l2_write_data}, 0);
    rst = 1'b1;

    // read hit, r0
    step();
    push_acc(0, 32'h40, 0);
    push_l2(0, 32'hDEAD_BEEF);
    push_resp(2'b01, 32'hDEAD_BEEF, 3);
    req(0, 0, 32'h0000_0040, 0);
    wait_done(1, 20);
    chk("hit_strobe_cycle", strobe_cyc - start[0], 1);
    chk("hit_miss_count", miss_count, 0);

    // read miss with refill, r1
    step();
    push_acc(0, 32'h1234, 0);
    push_acc(0, 32'h1234, 0);
    push_l2(1, 0);
    push_l2(0, 32'h5555_1234);
    beat_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    push_resp(2'b10, 32'h5555_1234, 11);
    req_cycles = 0; f0 = fill_pulses; s0 = strobe_cnt;
    req(1, 0, 32'h0000_1234, 0);
    wait_done(1, 40);
    chk("miss_fills", fill_pulses - f0, 4);
    chk("miss_strobes", strobe_cnt - s0, 2);
    chk("miss_memreq_cycles", req_cycles, 1);
    chk("miss_count_1", miss_count, 1);

    // both requesters held: grants alternate
    step();
    keep = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_acc(0, (i % 2 == 0) ? 32'h100 : 32'h200, 0);
      push_l2(0, 32'hF001 + 32'(i));
    end
    push_resp(2'b01, 32'hF001, 3);
    push_resp(2'b10, 32'hF002, -1);
    push_resp(2'b01, 32'hF003, -1);
    push_resp(2'b10, 32'hF004, -1);
    req(0, 0, 32'h100, 0);
    req(1, 0, 32'h200, 0);
    wait_done(4, 60);
    keep = 1'b0;
    req_valid = '0;

    // write hit leaves resp_rdata unchanged
    step();
    push_acc(1, 32'h80, 32'hCAFE_0001);
    push_l2(0, 32'hBAD0_BAD0);
    push_resp(2'b01, 32'hF004, 3);
    req(0, 1, 32'h80, 32'hCAFE_0001);
    wait_done(1, 20);

    // late ack and gapped beats
    step();
    ack_delay = 5;
    rv_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    push_acc(0, 32'h2008, 0);
    push_acc(0, 32'h2008, 0);
    push_l2(1, 0);
    push_l2(0, 32'h7777_2008);
    push_resp(2'b01, 32'h7777_2008, 18);
    req_cycles = 0; f0 = fill_pulses;
    req(0, 0, 32'h0000_2008, 0);
    wait_done(1, 60);
    chk("gap_memreq_cycles", req_cycles, 6);
    chk("gap_fills", fill_pulses - f0, 4);
    chk("miss_count_2", miss_count, 2);
    ack_delay = 0;

    // reset in the middle of a refill
    step();
    push_acc(0, 32'h3000, 0);
    push_l2(1, 0);
    req(1, 0, 32'h0000_3000, 0);
    wait_fill(2, 40);
    chk("pre_rst_miss_count", miss_count, 3);
    rst = 1'b0;
    force_rv = 1'b1;
    req_valid = '0;
    fill_q.delete(); resp_q.delete();
    acc_q.delete(); l2_q.delete(); rv_q.delete();
    filling = 1'b0; prev_ack = 1'b0; prev_strobe = 1'b0;
    d0 = done_cnt;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_fill_en", fill_en, 0);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_miss_count", miss_count, 0);
    chk("midrst_rdata", resp_rdata, 0);
    rst = 1'b1;
    repeat (4) step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_no_done", done_cnt, d0);
    force_rv = 1'b0;

    // miss counter saturation at all-ones
    step();
    repeat (15) push_l2(1, 0);
    push_l2(0, 32'h1111);
    repeat (16) push_acc(0, 32'h4000, 0);
    push_resp(2'b01, 32'h1111, -1);
    req(0, 0, 32'h0000_4000, 0);
    wait_done(1, 400);
    chk("sat_reach", miss_count, 4'hF);
    step();
    push_l2(1, 0);
    push_l2(0, 32'h2222);
    push_acc(0, 32'h4010, 0);
    push_acc(0, 32'h4010, 0);
    push_resp(2'b01, 32'h2222, -1);
    req(0, 0, 32'h0000_4010, 0);
    wait_done(1, 60);
    chk("sat_hold", miss_count, 4'hF);
    step();
    chk("resp_q_left", resp_q.size(), 0);
    chk("acc_q_left", acc_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
